// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding,
// default bit period and the parity helper.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Data is zero-padded to 9 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
module uart_sync2 (
  input  logic clk,
  input  logic nRST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, false-start rejection,
// valid/ready output with framing, parity and overrun flags.
//   state  | meaning
//   IDLE   | waiting for a low on the synchronised line
//   START  | half-bit wait, then confirm the start bit
//   DATA   | sample DATA_BITS bits, LSB first
//   PARITY | sample and check the parity bit
//   STOP   | sample STOP_BITS stop bits, present the word on the last one
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 rx_input_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy,
  output logic [2:0]           rx_state
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = 4;

  logic                 rxs;
  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q, par_err_q;
  logic                 half_tc, bit_tc, last_data, last_stop, load;

  uart_sync2 u_sync (
    .clk  (clk),
    .nRST (nRST),
    .d    (rx_input_data),
    .q    (rxs)
  );

  assign half_tc   = (cyc_cnt == CW'(HALF - 1));
  assign bit_tc    = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
  assign load      = (state == STOP) && bit_tc && last_stop;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxs) state_nxt = START;
      START:   if (half_tc) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (bit_tc && last_data) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_tc) state_nxt = STOP;
      STOP:    if (bit_tc && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cyc_cnt     <= '0;
          bit_cnt     <= '0;
          frame_err_q <= 1'b0;
          par_err_q   <= 1'b0;
        end
        START: cyc_cnt <= half_tc ? '0 : cyc_cnt + 1'b1;
        DATA: begin
          if (bit_tc) begin
            cyc_cnt <= '0;
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tc) begin
            cyc_cnt   <= '0;
            par_err_q <= (rxs != parity_bit(9'(shift_q), PARITY_ODD != 0));
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tc) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (!rxs) frame_err_q <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: cyc_cnt <= '0;
      endcase
    end
  end

  // The final stop sample is folded in directly so the word appears one cycle earlier.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (load) begin
      rx_data     <= shift_q;
      rx_valid    <= 1'b1;
      frame_err   <= frame_err_q | ~rxs;
      parity_err  <= par_err_q;
      overrun_err <= rx_valid & ~rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign rx_busy  = (state != IDLE);
  assign rx_state = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 8N2 receivers on one shared line.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int BT   = CPB * 10;

  logic clk = 1'b0;
  logic nRST, rx_line, rx_ready;

  logic [7:0] a_data, p_data, s_data;
  logic       a_valid, a_ferr, a_perr, a_oerr, a_busy;
  logic       p_valid, p_ferr, p_perr, p_oerr, p_busy;
  logic       s_valid, s_ferr, s_perr, s_oerr, s_busy;
  logic [2:0] a_state, p_state, s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .nRST(nRST), .rx_input_data(rx_line), .rx_data(a_data),
    .rx_valid(a_valid), .rx_ready(rx_ready), .frame_err(a_ferr),
    .parity_err(a_perr), .overrun_err(a_oerr), .rx_busy(a_busy), .rx_state(a_state));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .nRST(nRST), .rx_input_data(rx_line), .rx_data(p_data),
    .rx_valid(p_valid), .rx_ready(rx_ready), .frame_err(p_ferr),
    .parity_err(p_perr), .overrun_err(p_oerr), .rx_busy(p_busy), .rx_state(p_state));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut_s (
    .clk(clk), .nRST(nRST), .rx_input_data(rx_line), .rx_data(s_data),
    .rx_valid(s_valid), .rx_ready(rx_ready), .frame_err(s_ferr),
    .parity_err(s_perr), .overrun_err(s_oerr), .rx_busy(s_busy), .rx_state(s_state));

  int         a_rises = 0;
  logic       a_prev  = 1'b0;
  logic       ff_arm  = 1'b0;
  logic       ff_seen = 1'b0;
  logic       cap_en  = 1'b0;
  logic [7:0] cap_q[$];

  always @(negedge clk) begin
    if (a_valid && !a_prev) begin
      a_rises++;
      if (cap_en) cap_q.push_back(a_data);
    end
    if (ff_arm && a_valid && a_data == 8'hFF) ff_seen = 1'b1;
    a_prev = a_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int t);
    rx_line = b;
    #(t);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                            input logic stop1, input logic two_stop, input logic stop2,
                            input int bt);
    drive(1'b0, bt);
    for (int i = 0; i < 8; i++) drive(d[i], bt);
    if (par_en) drive(par, bt);
    drive(stop1, bt);
    if (two_stop) drive(stop2, bt);
    rx_line = 1'b1;
  endtask

  task automatic idle(input int nbits);
    rx_line = 1'b1;
    #(nbits * BT);
  endtask

  task automatic ack();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    rx_line  = 1'b1;
    rx_ready = 1'b1;
    nRST     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", {a_data, a_valid, a_ferr, a_perr, a_oerr, a_busy, a_state}, 32'h0);
    check("rst_p", {p_data, p_valid, p_ferr, p_perr, p_oerr, p_busy, p_state}, 32'h0);
    check("rst_s", {s_data, s_valid, s_ferr, s_perr, s_oerr, s_busy, s_state}, 32'h0);
    nRST = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // 1: 0xA5 8N1 with latency measured from the falling pin edge
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_valid && n < 400);
        check("t1_latency", n, 155);
        check("t1_data", a_data, 8'hA5);
        check("t1_errs", {a_ferr, a_perr, a_oerr}, 3'b000);
        @(posedge clk); #1;
        check("t1_valid_clear", a_valid, 1'b0);
      end
    join
    idle(3);
    check("t1_one_pulse", a_rises, 1);

    // 2: even parity on 0x07
    rx_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t2_good_valid", p_valid, 1'b1);
    check("t2_good_data", p_data, 8'h07);
    check("t2_good_perr", p_perr, 1'b0);
    ack();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t2_bad_data", p_data, 8'h07);
    check("t2_bad_perr", p_perr, 1'b1);
    check("t2_bad_ferr", p_ferr, 1'b0);
    ack();
    check("t2_ack_clear", {p_valid, p_perr}, 2'b00);

    // 3: framing errors on 0x3C
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BT);
    idle(3);
    check("t3_stop0_data", a_data, 8'h3C);
    check("t3_stop0_ferr", a_ferr, 1'b1);
    ack();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BT);
    idle(3);
    check("t3_stop2_data", s_data, 8'h3C);
    check("t3_stop2_ferr", s_ferr, 1'b1);
    idle(12);
    ack();

    // 4: overrun, then load coinciding with accept
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t4_first_data", a_data, 8'h11);
    check("t4_first_oerr", a_oerr, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t4_ovr_valid", a_valid, 1'b1);
    check("t4_ovr_data", a_data, 8'h22);
    check("t4_ovr_oerr", a_oerr, 1'b1);
    ack();
    check("t4_ack_clear", {a_valid, a_ferr, a_perr, a_oerr}, 4'b0000);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
      begin
        repeat (154) @(posedge clk);
        #1;
        check("t4_same_old", a_data, 8'h33);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_same_valid", a_valid, 1'b1);
        check("t4_same_data", a_data, 8'h44);
        check("t4_same_oerr", a_oerr, 1'b0);
        @(posedge clk); #1;
        check("t4_same_clear", a_valid, 1'b0);
        rx_ready = 1'b0;
      end
    join
    idle(3);

    // 5: short glitch rejected, then 0x5A
    r0 = a_rises;
    rx_line = 1'b0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; n++; end
    rx_line = 1'b1;
    check("t5_busy_seen", a_busy, 1'b1);
    while (a_busy && n < 100) begin @(posedge clk); #1; n++; end
    check("t5_busy_drop", (n <= HALF + 3), 1'b1);
    idle(3);
    check("t5_no_word", a_rises, r0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t5_data", a_data, 8'h5A);
    check("t5_valid_errs", {a_valid, a_ferr, a_perr, a_oerr}, 4'b1000);
    ack();

    // 6: reset mid-DATA of 0xFF, then 0x81
    ff_arm = 1'b1;
    drive(1'b0, BT);
    drive(1'b1, 3 * BT);
    check("t6_in_data", a_state, 3'd2);
    nRST = 1'b0;
    #30;
    check("t6_rst_state", {a_valid, a_busy, a_state}, 5'b0);
    nRST = 1'b1;
    idle(12);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT);
    idle(3);
    check("t6_data", a_data, 8'h81);
    check("t6_valid", a_valid, 1'b1);
    ack();
    check("t6_no_ff", ff_seen, 1'b0);

    // back-to-back frames at -1.9% and +1.9% bit period
    rx_ready = 1'b1;
    cap_en   = 1'b1;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT - 3);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT - 3);
    send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT - 3);
    send_frame(8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT + 3);
    send_frame(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT + 3);
    send_frame(8'hDE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BT + 3);
    idle(3);
    cap_en = 1'b0;
    check("b2b_count", cap_q.size(), 6);
    if (cap_q.size() == 6) begin
      check("b2b_w0", cap_q[0], 8'h12);
      check("b2b_w1", cap_q[1], 8'h34);
      check("b2b_w2", cap_q[2], 8'h56);
      check("b2b_w3", cap_q[3], 8'h9A);
      check("b2b_w4", cap_q[4], 8'hBC);
      check("b2b_w5", cap_q[5], 8'hDE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
